// File: rtl/lisnoc16_sysctrl_cmd_sender_if.sv
// Handshake bundle between the command sender and its host / NoC neighbours.
// The sender sits on the slave side; the environment drives through master.
interface lisnoc16_sysctrl_cmd_sender_if;
    localparam int FLIT_W = 18;
    localparam int CMD_W  = 7;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_bits;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic              out_ready;
    logic [FLIT_W-1:0] in_flit;
    logic              in_valid;
    logic              in_ready;

    modport slave (
        input  cmd_valid, cmd_bits, out_ready, in_flit, in_valid,
        output cmd_ready, out_flit, out_valid, in_ready
    );
    modport master (
        output cmd_valid, cmd_bits, out_ready, in_flit, in_valid,
        input  cmd_ready, out_flit, out_valid, in_ready
    );
endinterface

// File: rtl/lisnoc16_sysctrl_cmd_sender.sv
// Sends one system-control command flit and waits for its echo as ACK,
// resending on timeout up to MAX_RETRY times before flagging an error.
module lisnoc16_sysctrl_cmd_sender #(
    parameter int SYSCTRL_DEST = 0,
    parameter int TIMEOUT      = 255,
    parameter int MAX_RETRY    = 3
) (
    input  logic clk,
    input  logic rst,
    lisnoc16_sysctrl_cmd_sender_if.slave bus,
    output logic busy,
    output logic done,
    output logic err,
    output logic stray
);
    // Flit layout: type [17:16], dest [15:10], class [9:7], payload [6:0]
    localparam logic [1:0]  TYPE_SINGLE   = 2'b11;
    localparam logic [2:0]  CLASS_CONTROL = 3'b111;
    localparam logic [5:0]  DEST_F        = 6'(SYSCTRL_DEST);
    localparam logic [15:0] TMO_LAST      = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MAX     = 4'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

    state_e      state_q, state_d;
    logic [6:0]  cmd_q, cmd_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic        done_q, done_d, err_q, err_d, stray_q, stray_d;
    logic        ack_match;
    logic        unused_dest;

    // The ACK is the command echoed back; its dest field carries no meaning.
    assign ack_match = bus.in_valid
                    && bus.in_flit[17:16] == TYPE_SINGLE
                    && bus.in_flit[9:7]   == CLASS_CONTROL
                    && bus.in_flit[6:0]   == cmd_q;
    assign unused_dest = ^bus.in_flit[15:10];

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.in_ready  = (state_q != SEND);
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_flit  = {TYPE_SINGLE, DEST_F, CLASS_CONTROL, cmd_q};
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign stray         = stray_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            timer_q <= '0;
            retry_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            done_q  <= done_d;
            err_q   <= err_d;
            stray_q <= stray_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        timer_d = timer_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        stray_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Nothing is outstanding, so any arriving flit is stray.
                stray_d = bus.in_valid;
                if (bus.cmd_valid) begin
                    cmd_d   = bus.cmd_bits;
                    retry_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                if (ack_match) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (timer_q == TMO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 4'd1;
                        state_d = SEND;
                        stray_d = bus.in_valid;
                    end else begin
                        // err takes the single pulse slot; a coincident stray is dropped
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                    stray_d = bus.in_valid;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/lisnoc16_sysctrl_cmd_sender.md
LISNOC16_SYSCTRL_CMD_SENDER -- requirements
Module: lisnoc16_sysctrl_cmd_sender

Interface
REQ-001 Parameter SYSCTRL_DEST, default 0: NoC destination of the system control tile.
REQ-002 Parameter TIMEOUT, default 255: number of WAIT cycles without an ACK before a resend; legal range 1..65535.
REQ-003 Parameter MAX_RETRY, default 3: number of resends allowed before the error is flagged; legal range 0..15.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-low reset.
REQ-006 Port cmd_valid, input, 1: host presents a command.
REQ-007 Port cmd_ready, output, 1: block accepts a command this cycle.
REQ-008 Port cmd_bits, input, `PACKET16_CLASS_LSB: command bit vector (reset, clk, cpu and monitoring bits per lisnoc16_system_control_def.vh).
REQ-009 Port out_flit, output, `FLIT16_WIDTH: flit toward the NoC.
REQ-010 Port out_valid, output, 1: out_flit is valid.
REQ-011 Port out_ready, input, 1: NoC accepts out_flit.
REQ-012 Port in_flit, input, `FLIT16_WIDTH: flit from the NoC (the ACK path).
REQ-013 Port in_valid, input, 1: in_flit is valid.
REQ-014 Port in_ready, output, 1: block consumes in_flit.
REQ-015 Port busy, output, 1: high whenever the state is not IDLE.
REQ-016 Port done, output, 1: one-cycle pulse when a command is acknowledged.
REQ-017 Port err, output, 1: one-cycle pulse when retries are exhausted.
REQ-018 Port stray, output, 1: one-cycle pulse when a non-matching flit is consumed.

Function
REQ-019 States and handshake signals:
- IDLE: cmd_ready=1, in_ready=1, out_valid=0.
- SEND: cmd_ready=0, in_ready=0, out_valid=1.
- WAIT: cmd_ready=0, in_ready=1, out_valid=0.
REQ-020 IDLE with cmd_valid=1: capture cmd_bits into cmd_reg, clear retry_cnt, next state SEND.
REQ-021 out_flit fields in SEND:
- type = `FLIT16_TYPE_SINGLE
- dest = SYSCTRL_DEST
- class = `PACKET16_CLASS_CONTROL
- bits [`PACKET16_CLASS_LSB-1:0] = cmd_reg
- out_flit is don't-care outside SEND.
REQ-022 out_flit and out_valid stay stable in SEND until out_ready=1; on out_ready=1, next state WAIT and timer cleared to 0.
REQ-023 Each WAIT cycle with no matching ACK increments the timer by 1; the timer is 16 bits and never wraps (bounded by TIMEOUT).
REQ-024 Matching ACK: in_valid=1, type SINGLE, class CONTROL, payload equal to cmd_reg; the dest field is ignored.
REQ-025 Matching ACK in WAIT: next state IDLE; done=1 in the following cycle.
REQ-026 Non-matching flit in WAIT or IDLE: consumed and dropped, stray=1 the following cycle, no state change.
REQ-027 Timeout in WAIT (timer == TIMEOUT-1 with no matching ACK that cycle):
- retry_cnt < MAX_RETRY: retry_cnt+1, next state SEND with the same cmd_reg.
- otherwise: next state IDLE, err=1 the following cycle.
REQ-028 Matching ACK in the same cycle as the timeout condition: the ACK wins (done, no resend, no err).
REQ-029 A late ACK arriving in IDLE after err is treated as stray.
REQ-030 done, err and stray are registered, mutually exclusive, and never high for two consecutive cycles from one event.
REQ-031 Command-to-flit latency: cmd accepted at edge N gives out_valid=1 in the cycle after edge N.
REQ-032 A new command is accepted no earlier than the cycle after done or err.

Reset
REQ-033 rst=0 asynchronously forces:
- state IDLE;
- timer, retry_cnt and cmd_reg to 0;
- done, err and stray to 0.
REQ-034 During reset: out_valid=0, cmd_ready=1, in_ready=1, busy=0.
REQ-035 Reset asserted mid-SEND or mid-WAIT abandons the command with no done or err pulse; a flit presented during reset is not counted as stray.

Verification
REQ-036 Command, immediate ACK: cmd_bits=7'h01 accepted, out_ready=1, matching ACK 2 cycles later -> exactly one flit sent, done pulse, busy low afterwards.
REQ-037 Backpressure: out_ready held 0 for 10 cycles -> out_flit and out_valid constant for 10 cycles, timer not running.
REQ-038 Retry exhaustion: TIMEOUT=4, MAX_RETRY=2, no ACK -> 3 identical flits sent, err pulse 4 cycles after the third flit is accepted.
REQ-039 Stray and ACK/timeout collision: wrong-payload ACK in WAIT -> stray pulse, then matching ACK on the timeout cycle -> done, no fourth flit, no err.
REQ-040 Reset mid-WAIT: rst low 1 cycle during WAIT -> state IDLE, no done or err, next command starts with retry_cnt=0.
